// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the parametrised serial pattern detector.
// Holds the FSM state encoding and the default size constants.
package seq_det_pkg;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_LEN_W = 4;
    localparam int DEF_CNT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: clears on clr, counts on inc, sticks at all-ones.
// Ports: clk, reset_n (async active-low), clr, inc, q[CNT_W-1:0].
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc && (q != '1)) begin
            q <= q + 1'b1;
        end
    end

endmodule

// File: rtl/param_seq_detector.sv
// Runtime-programmable serial bit-pattern detector with overlap mode,
// input qualifier and saturating match counter.
// Ports: clk, reset_n, cfg_load, pattern, pat_len, overlap_en (config);
//        din, din_valid (stream); seq_detected, match_count, cfg_err (status).
module param_seq_detector
    import seq_det_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = DEF_LEN_W,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] pattern,
    input  logic [LEN_W-1:0] pat_len,
    input  logic             overlap_en,
    input  logic             din,
    input  logic             din_valid,
    output logic             seq_detected,
    output logic [CNT_W-1:0] match_count,
    output logic             cfg_err
);

    state_t             state;
    logic [PAT_W-1:0]   pat_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovl_q;

    // Only PAT_W-1 bits of history are needed: the newest bit is din itself.
    logic [PAT_W-2:0]   history;
    logic [LEN_W-1:0]   fill;

    logic [PAT_W-1:0]   hist_nxt;
    logic [PAT_W-1:0]   mask;
    logic [LEN_W:0]     fill_inc;
    logic [LEN_W-1:0]   fill_sat;
    logic               cfg_legal;
    logic               shift_en;
    logic               match;

    assign cfg_legal = (pat_len != '0) && (pat_len <= LEN_W'(PAT_W));
    assign shift_en  = (state == ST_RUN) && din_valid && !cfg_load;
    assign hist_nxt  = {history, din};
    assign fill_inc  = {1'b0, fill} + 1'b1;
    assign fill_sat  = (fill_inc > (LEN_W+1)'(PAT_W)) ? LEN_W'(PAT_W)
                                                     : fill_inc[LEN_W-1:0];

    always_comb begin
        mask = '0;
        for (int i = 0; i < PAT_W; i++) begin
            mask[i] = (LEN_W'(i) < len_q);
        end
    end

    assign match = shift_en
                && (((hist_nxt ^ pat_q) & mask) == '0)
                && (fill_inc >= {1'b0, len_q});

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            pat_q        <= '0;
            len_q        <= '0;
            ovl_q        <= 1'b0;
            history      <= '0;
            fill         <= '0;
            seq_detected <= 1'b0;
            cfg_err      <= 1'b0;
        end else if (cfg_load) begin
            pat_q        <= pattern;
            len_q        <= pat_len;
            ovl_q        <= overlap_en;
            history      <= '0;
            fill         <= '0;
            seq_detected <= 1'b0;
            cfg_err      <= !cfg_legal;
            state        <= cfg_legal ? ST_RUN : ST_IDLE;
        end else begin
            seq_detected <= match;
            if (shift_en) begin
                history <= hist_nxt[PAT_W-2:0];
                // Non-overlap restarts the window so a new match needs fresh bits.
                if (match && !ovl_q) begin
                    fill <= '0;
                end else begin
                    fill <= fill_sat;
                end
            end
        end
    end

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (cfg_load),
        .inc     (match),
        .q       (match_count)
    );

endmodule
